// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper: FSM states, score width
// and active-low seven-segment patterns (segment order g..a, bit 6 = g).
package score_keeper_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RESTART = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

endpackage

// File: rtl/score_keeper_seg7.sv
// Active-low seven-segment decoder; anything above 9 shows blank.
module seg7
  import score_keeper_pkg::*;
(
  input  logic [SCORE_W-1:0] val_i,
  output logic [6:0]         seg_o
);

  // Pure lookup from digit value to segment pattern
  always_comb begin
    seg_o = SEG_BLANK;
    case (val_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Match score keeper: counts round wins per side, holds the result for a
// while, pulses round_rst to restart play, and latches the match winner.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l_win,
  input  logic       r_win,
  input  logic       new_match,
  output logic       round_rst,
  output logic       match_over,
  output logic [1:0] winner,
  output logic [6:0] hex_l,
  output logic [6:0] hex_r
);

  localparam int                 CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         winner_q, winner_d;
  logic               over_q, over_d;
  logic [SCORE_W-1:0] inc_l, inc_r;

  assign inc_l = score_l_q + SCORE_W'(1);
  assign inc_r = score_r_q + SCORE_W'(1);

  // State and score registers; reset aborts straight to a fresh match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_PLAY;
      score_l_q <= '0;
      score_r_q <= '0;
      cnt_q     <= '0;
      winner_q  <= WIN_NONE;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
      over_q    <= over_d;
    end
  end

  // Next-state logic; only PLAY scores, only DONE honours new_match
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    over_d    = over_q;
    case (state_q)
      ST_PLAY: begin
        // a simultaneous l_win/r_win is ambiguous and dropped
        if (l_win && !r_win) begin
          score_l_d = inc_l;
          if (inc_l == WIN_S) begin
            state_d  = ST_DONE;
            winner_d = WIN_LEFT;
            over_d   = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end else if (r_win && !l_win) begin
          score_r_d = inc_r;
          if (inc_r == WIN_S) begin
            state_d  = ST_DONE;
            winner_d = WIN_RIGHT;
            over_d   = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_RESTART;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RESTART: state_d = ST_PLAY;
      ST_DONE: begin
        if (new_match) begin
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = WIN_NONE;
          over_d    = 1'b0;
          state_d   = ST_RESTART;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  assign round_rst  = (state_q == ST_RESTART);
  assign match_over = over_q;
  assign winner     = winner_q;

  seg7 u_seg_l (.val_i(score_l_q), .seg_o(hex_l));
  seg7 u_seg_r (.val_i(score_r_q), .seg_o(hex_r));

endmodule

// File: tb/tb_score_keeper.sv
// Table-driven bench for score_keeper with an expected-output queue,
// plus hand sequences for reset-in-HOLD and round_rst timing.
module tb_score_keeper;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       l_win = 1'b0, r_win = 1'b0, new_match = 1'b0;
  logic       round_rst, match_over;
  logic [1:0] winner;
  logic [6:0] hex_l, hex_r;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic       l, r, nm;
    logic [6:0] hl, hr;
    logic       rr, mo;
    logic [1:0] w;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  score_keeper #(.WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .l_win(l_win), .r_win(r_win),
    .new_match(new_match), .round_rst(round_rst), .match_over(match_over),
    .winner(winner), .hex_l(hex_l), .hex_r(hex_r)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic l, logic r, logic nm, logic [6:0] hl,
                              logic [6:0] hr, logic rr, logic mo, logic [1:0] w);
    vec_t v;
    v.l = l; v.r = r; v.nm = nm; v.hl = hl; v.hr = hr;
    v.rr = rr; v.mo = mo; v.w = w;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, vec_t e);
    chk({tag, " hex_l"}, {1'b0, hex_l}, {1'b0, e.hl});
    chk({tag, " hex_r"}, {1'b0, hex_r}, {1'b0, e.hr});
    chk({tag, " round_rst"}, {7'b0, round_rst}, {7'b0, e.rr});
    chk({tag, " match_over"}, {7'b0, match_over}, {7'b0, e.mo});
    chk({tag, " winner"}, {6'b0, winner}, {6'b0, e.w});
  endtask

  // Called at a negedge: drive, clock, then compare at the next negedge
  task automatic cyc(int idx, vec_t v);
    vec_t e;
    l_win = v.l; r_win = v.r; new_match = v.nm;
    sb.push_back(v);
    @(posedge clk);
    #1;
    l_win = 1'b0; r_win = 1'b0; new_match = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    chk_all($sformatf("v%0d", idx), e);
  endtask

  initial begin
    int cnt;
    int seen;

    // both-win ignored, left wins a round (l_win and new_match ignored in HOLD)
    tbl.push_back(mk(1,1,0, D0,D0, 0,0,2'b00));
    tbl.push_back(mk(0,0,0, D0,D0, 0,0,2'b00));
    tbl.push_back(mk(1,0,0, D1,D0, 0,0,2'b00));
    tbl.push_back(mk(1,0,0, D1,D0, 0,0,2'b00));
    tbl.push_back(mk(0,0,1, D1,D0, 0,0,2'b00));
    tbl.push_back(mk(0,1,0, D1,D0, 0,0,2'b00));
    tbl.push_back(mk(0,0,0, D1,D0, 1,0,2'b00));
    tbl.push_back(mk(0,0,0, D1,D0, 0,0,2'b00));
    // right takes three rounds
    tbl.push_back(mk(0,1,0, D1,D1, 0,0,2'b00));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0, D1,D1, 0,0,2'b00));
    tbl.push_back(mk(0,0,0, D1,D1, 1,0,2'b00));
    tbl.push_back(mk(0,0,0, D1,D1, 0,0,2'b00));
    tbl.push_back(mk(0,1,0, D1,D2, 0,0,2'b00));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0, D1,D2, 0,0,2'b00));
    tbl.push_back(mk(0,0,0, D1,D2, 1,0,2'b00));
    tbl.push_back(mk(0,0,0, D1,D2, 0,0,2'b00));
    tbl.push_back(mk(0,1,0, D1,D3, 0,1,2'b01));
    // DONE: wins ignored, no round_rst, then new match
    tbl.push_back(mk(1,0,0, D1,D3, 0,1,2'b01));
    tbl.push_back(mk(0,1,0, D1,D3, 0,1,2'b01));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0,0,0, D1,D3, 0,1,2'b01));
    tbl.push_back(mk(0,0,1, D0,D0, 1,0,2'b00));
    tbl.push_back(mk(0,0,0, D0,D0, 0,0,2'b00));

    // reset values while held in reset
    #12;
    chk_all("reset", mk(0,0,0, D0,D0, 0,0,2'b00));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) cyc(i, tbl[i]);

    // reset in the middle of HOLD aborts immediately, no round_rst follows
    cyc(100, mk(1,0,0, D1,D0, 0,0,2'b00));
    cyc(101, mk(0,0,0, D1,D0, 0,0,2'b00));
    #1 rst = 1'b0;
    #1 chk_all("rst_hold", mk(0,0,0, D0,D0, 0,0,2'b00));
    @(negedge clk);
    chk_all("rst_hold_low", mk(0,0,0, D0,D0, 0,0,2'b00));
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (round_rst) seen++;
    end
    chk("rst_hold no round_rst", 8'(seen), 8'd0);

    // round_rst arrives 5 cycles after the win edge and lasts one cycle
    l_win = 1'b1;
    @(posedge clk);
    #1 l_win = 1'b0;
    @(negedge clk);
    chk("lat hex_l", {1'b0, hex_l}, {1'b0, D1});
    cnt = 1;
    seen = 0;
    while (cnt < 20 && !seen) begin
      @(negedge clk);
      cnt++;
      if (round_rst) seen = 1;
    end
    chk("lat round_rst cycles", 8'(seen ? cnt : 0), 8'd5);
    @(negedge clk);
    chk("lat round_rst width", {7'b0, round_rst}, 8'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
